// File: rtl/jtag_tap_param.sv
// IEEE 1149.1-style TAP: 16-state controller, IR_W-bit instruction register,
// internal BYPASS/IDCODE registers and select strobes for external BSR/user chains.
module jtag_tap_param #(
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
  parameter int          OP_EXTEST  = 0,
  parameter int          OP_SAMPLE  = 1,
  parameter int          OP_IDCODE  = 2,
  parameter int          OP_USER    = 8
) (
  input  logic            TCLK,
  input  logic            TRST,
  input  logic            TMS,
  input  logic            TDI,
  input  logic            bsr_tdo,
  input  logic            user_tdo,
  output logic [3:0]      tap_state,
  output logic [IR_W-1:0] ir_q,
  output logic            capture_dr,
  output logic            shift_dr,
  output logic            update_dr,
  output logic            sel_bsr,
  output logic            sel_user,
  output logic            bsr_mode,
  output logic            tdo,
  output logic            tdo_en
);

  typedef enum logic [3:0] {
    S_TLR   = 4'hF, S_RTI   = 4'hC,
    S_SELDR = 4'h7, S_CAPDR = 4'h6, S_SHDR = 4'h2, S_EX1DR = 4'h1,
    S_PAUDR = 4'h3, S_EX2DR = 4'h0, S_UPDDR = 4'h5,
    S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA, S_EX1IR = 4'h9,
    S_PAUIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD
  } state_t;

  localparam logic [IR_W-1:0] L_EXTEST = IR_W'(OP_EXTEST);
  localparam logic [IR_W-1:0] L_SAMPLE = IR_W'(OP_SAMPLE);
  localparam logic [IR_W-1:0] L_IDCODE = IR_W'(OP_IDCODE);
  localparam logic [IR_W-1:0] L_USER   = IR_W'(OP_USER);
  localparam logic [IR_W-1:0] L_IR_CAP = {{(IR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [IR_W-1:0]   r_ir_sr;
  logic [IR_W-1:0]   r_ir_q;
  logic [31:0]       r_idcode;
  logic              r_bypass;
  logic              r_tdo;
  logic              r_tdo_en;

  logic w_is_bsr;
  logic w_is_user;
  logic w_sel_id;
  logic w_sel_byp;
  logic w_tdo_nxt;

  // TAP controller state register, advanced by TMS on rising TCLK
  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      r_state <= S_TLR;
    end else begin
      case (r_state)
        S_TLR:   r_state <= TMS ? S_TLR   : S_RTI;
        S_RTI:   r_state <= TMS ? S_SELDR : S_RTI;
        S_SELDR: r_state <= TMS ? S_SELIR : S_CAPDR;
        S_CAPDR: r_state <= TMS ? S_EX1DR : S_SHDR;
        S_SHDR:  r_state <= TMS ? S_EX1DR : S_SHDR;
        S_EX1DR: r_state <= TMS ? S_UPDDR : S_PAUDR;
        S_PAUDR: r_state <= TMS ? S_EX2DR : S_PAUDR;
        S_EX2DR: r_state <= TMS ? S_UPDDR : S_SHDR;
        S_UPDDR: r_state <= TMS ? S_SELDR : S_RTI;
        S_SELIR: r_state <= TMS ? S_TLR   : S_CAPIR;
        S_CAPIR: r_state <= TMS ? S_EX1IR : S_SHIR;
        S_SHIR:  r_state <= TMS ? S_EX1IR : S_SHIR;
        S_EX1IR: r_state <= TMS ? S_UPDIR : S_PAUIR;
        S_PAUIR: r_state <= TMS ? S_EX2IR : S_PAUIR;
        S_EX2IR: r_state <= TMS ? S_UPDIR : S_SHIR;
        S_UPDIR: r_state <= TMS ? S_SELDR : S_RTI;
        default: r_state <= S_TLR;
      endcase
    end
  end

  // Instruction shift register and the active instruction it updates
  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      r_ir_sr <= L_IR_CAP;
      r_ir_q  <= L_IDCODE;
    end else begin
      if (r_state == S_CAPIR) begin
        r_ir_sr <= L_IR_CAP;
      end else if (r_state == S_SHIR) begin
        r_ir_sr <= {TDI, r_ir_sr[IR_W-1:1]};
      end else begin
        r_ir_sr <= r_ir_sr;
      end
      if (r_state == S_TLR) begin
        r_ir_q <= L_IDCODE;
      end else if (r_state == S_UPDIR) begin
        r_ir_q <= r_ir_sr;
      end else begin
        r_ir_q <= r_ir_q;
      end
    end
  end

  // Opcode priority: BSR, then user chain, then IDCODE; anything else is BYPASS
  assign w_is_bsr  = (r_ir_q == L_EXTEST) || (r_ir_q == L_SAMPLE);
  assign w_is_user = !w_is_bsr && (r_ir_q == L_USER);
  assign w_sel_id  = !w_is_bsr && !w_is_user && (r_ir_q == L_IDCODE);
  assign w_sel_byp = !w_is_bsr && !w_is_user && !w_sel_id;

  // Internal data registers: IDCODE and BYPASS, each active only when selected
  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      r_idcode <= IDCODE_VAL;
      r_bypass <= 1'b0;
    end else begin
      if (w_sel_id && r_state == S_CAPDR) begin
        r_idcode <= IDCODE_VAL;
      end else if (w_sel_id && r_state == S_SHDR) begin
        r_idcode <= {TDI, r_idcode[31:1]};
      end else begin
        r_idcode <= r_idcode;
      end
      if (w_sel_byp && r_state == S_CAPDR) begin
        r_bypass <= 1'b0;
      end else if (w_sel_byp && r_state == S_SHDR) begin
        r_bypass <= TDI;
      end else begin
        r_bypass <= r_bypass;
      end
    end
  end

  // Serial output source for the current state
  always_comb begin
    w_tdo_nxt = 1'b0;
    case (r_state)
      S_SHIR: w_tdo_nxt = r_ir_sr[0];
      S_SHDR: begin
        if (w_is_bsr) begin
          w_tdo_nxt = bsr_tdo;
        end else if (w_is_user) begin
          w_tdo_nxt = user_tdo;
        end else if (w_sel_id) begin
          w_tdo_nxt = r_idcode[0];
        end else begin
          w_tdo_nxt = r_bypass;
        end
      end
      default: w_tdo_nxt = 1'b0;
    endcase
  end

  // TDO and its enable launch on falling TCLK so the far end samples mid-cycle
  always_ff @(negedge TCLK or negedge TRST) begin
    if (!TRST) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_tdo_nxt;
      r_tdo_en <= (r_state == S_SHIR) || (r_state == S_SHDR);
    end
  end

  assign tap_state  = r_state;
  assign ir_q       = r_ir_q;
  assign capture_dr = (r_state == S_CAPDR);
  assign shift_dr   = (r_state == S_SHDR);
  assign update_dr  = (r_state == S_UPDDR);
  assign sel_bsr    = w_is_bsr;
  assign sel_user   = w_is_user;
  assign bsr_mode   = (r_ir_q == L_EXTEST);
  assign tdo        = r_tdo;
  assign tdo_en     = r_tdo_en;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param: reset, IDCODE, IR load, bypass, chains, pause, abort.
module tb_jtag_tap_param;

  logic       TCLK;
  logic       TRST;
  logic       TMS;
  logic       TDI;
  logic       bsr_tdo;
  logic       user_tdo;
  logic [3:0] tap_state;
  logic [3:0] ir_q;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic       sel_bsr;
  logic       sel_user;
  logic       bsr_mode;
  logic       tdo;
  logic       tdo_en;

  int n_pass  = 0;
  int n_total = 0;

  jtag_tap_param dut (
    .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
    .bsr_tdo(bsr_tdo), .user_tdo(user_tdo),
    .tap_state(tap_state), .ir_q(ir_q),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .sel_bsr(sel_bsr), .sel_user(sel_user), .bsr_mode(bsr_mode),
    .tdo(tdo), .tdo_en(tdo_en)
  );

  initial TCLK = 1'b0;
  always #5 TCLK = ~TCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply TMS/TDI, take one rising edge, return just after the following falling edge
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCLK);
    @(negedge TCLK);
    #1;
  endtask

  // From RTI: load v into the IR, return captured bits (LSB-first), end in RTI
  task automatic ir_scan(input logic [3:0] v, output logic [3:0] cap);
    cap = 4'h0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = tdo;
      tick(i == 3, v[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI: n-bit DR scan shifting d LSB-first, return tdo bits and tdo_en count
  task automatic dr_scan(input int n, input logic [31:0] d, output logic [31:0] q,
                         output int en_cnt);
    q = 32'h0;
    en_cnt = 0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      q[i] = tdo;
      if (tdo_en) en_cnt++;
      tick(i == n - 1, d[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0]  cap;
    logic [31:0] q;
    int          en;

    TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; bsr_tdo = 1'b0; user_tdo = 1'b0;
    #12;
    check("rst_state", 32'(tap_state), 32'hF);
    check("rst_ir_q", 32'(ir_q), 32'h2);
    check("rst_tdo_en", 32'(tdo_en), 32'h0);
    check("rst_tdo", 32'(tdo), 32'h0);
    check("rst_strobes", 32'({capture_dr, shift_dr, update_dr, sel_bsr, sel_user, bsr_mode}),
          32'h0);
    TRST = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    check("tlr_hold", 32'(tap_state), 32'hF);

    // IDCODE read straight out of reset
    tick(1'b0, 1'b0);
    dr_scan(32, 32'h0, q, en);
    check("idcode_val", q, 32'h1234_5679);
    check("idcode_en_cnt", 32'(en), 32'd32);
    check("idcode_en_off", 32'(tdo_en), 32'h0);

    // All-ones opcode: capture pattern and bypass delay
    ir_scan(4'hF, cap);
    check("ir_capture", 32'(cap), 32'h1);
    check("ir_q_F", 32'(ir_q), 32'hF);
    dr_scan(8, 32'hCD, q, en);
    check("bypass_F", q, 32'h9A);
    check("bypass_en_cnt", 32'(en), 32'd8);

    // Unknown opcode also selects bypass
    ir_scan(4'h5, cap);
    check("ir_q_5", 32'(ir_q), 32'h5);
    check("sel_5", 32'({sel_bsr, sel_user, bsr_mode}), 32'h0);
    dr_scan(8, 32'hCD, q, en);
    check("bypass_5", q, 32'h9A);

    // EXTEST routes the BSR and raises the strobes
    ir_scan(4'h0, cap);
    check("extest_sel", 32'({sel_bsr, sel_user, bsr_mode}), 32'h5);
    bsr_tdo = 1'b1; user_tdo = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("capture_dr", 32'({capture_dr, shift_dr, update_dr}), 32'h4);
    tick(1'b0, 1'b0);
    check("shift_dr", 32'({capture_dr, shift_dr, update_dr}), 32'h2);
    check("bsr_tdo_1", 32'(tdo), 32'h1);
    bsr_tdo = 1'b0;
    tick(1'b0, 1'b0);
    check("bsr_tdo_0", 32'(tdo), 32'h0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("update_dr", 32'({capture_dr, shift_dr, update_dr}), 32'h1);
    tick(1'b0, 1'b0);

    // SAMPLE selects BSR without driving pins
    ir_scan(4'h1, cap);
    check("sample_sel", 32'({sel_bsr, sel_user, bsr_mode}), 32'h4);

    // User chain
    ir_scan(4'h8, cap);
    check("user_sel", 32'({sel_bsr, sel_user, bsr_mode}), 32'h2);
    bsr_tdo = 1'b1; user_tdo = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("user_tdo_0", 32'(tdo), 32'h0);
    user_tdo = 1'b1;
    tick(1'b0, 1'b0);
    check("user_tdo_1", 32'(tdo), 32'h1);

    // Five TMS=1 edges from Shift-DR reach TLR; the next TLR edge restores IDCODE
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    check("tms5_tlr", 32'(tap_state), 32'hF);
    check("tms5_ir_kept", 32'(ir_q), 32'h8);
    tick(1'b1, 1'b0);
    check("tlr_ir_idcode", 32'(ir_q), 32'h2);

    // IDCODE with a pause after 10 bits
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    q = 32'h0;
    for (int i = 0; i < 10; i++) begin
      q[i] = tdo;
      tick(i == 9, 1'b0);
    end
    check("pause_ex1", 32'(tap_state), 32'h1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("pause_state", 32'(tap_state), 32'h3);
    check("pause_en", 32'(tdo_en), 32'h0);
    tick(1'b1, 1'b0);
    check("pause_ex2", 32'(tap_state), 32'h0);
    tick(1'b0, 1'b0);
    check("resume_shdr", 32'(tap_state), 32'h2);
    for (int i = 10; i < 32; i++) begin
      q[i] = tdo;
      tick(i == 31, 1'b0);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("pause_idcode", q, 32'h1234_5679);

    // Async reset two bits into an IR shift
    ir_scan(4'h8, cap);
    check("pre_abort_ir", 32'(ir_q), 32'h8);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("abort_in_shir", 32'({tap_state, 3'b000, tdo_en}), 32'hA1);
    TRST = 1'b0;
    #1;
    check("abort_state", 32'(tap_state), 32'hF);
    check("abort_ir_q", 32'(ir_q), 32'h2);
    check("abort_tdo_en", 32'(tdo_en), 32'h0);
    #1;
    TRST = 1'b1;
    tick(1'b1, 1'b0);
    check("post_abort", 32'({tap_state, ir_q}), 32'hF2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
